pipeline_hazard_ctrl: RTL

- Central hazard controller for the 5-stage pipelined ARM CPU.
- Drives the stall, flush and bubble controls for the PC, IF/ID and ID/EX registers, and generates the forwarding selects FWDA/FWDB for the EX-stage ALU operand muxes.
- Resolves three hazard classes: load-use data hazards (with configurable data-memory latency), B.cond-after-flag-set hazards, and taken-branch control hazards (with configurable penalty).
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/fwd_select.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] XZR = 5'd31;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Brief    : Per-operand forwarding select; the MEM result is younger than WB.
// Revision : 1.0
// ============================================================================
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       regwrite_mem,
    input  logic [4:0] target_mem,
    input  logic       regwrite_wb,
    input  logic [4:0] target_wb,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_REG;
        if (regwrite_mem && (target_mem != XZR) && (target_mem == src)) begin
            fwd = FWD_MEM;
        end else if (regwrite_wb && (target_wb != XZR) && (target_wb == src)) begin
            fwd = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush/bubble control and EX forwarding for the 5-stage CPU.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             uses_rn_ID,
    input  logic             uses_rm_ID,
    input  logic             condBr_ID,
    input  logic [4:0]       rn_EX,
    input  logic [4:0]       rm_EX,
    input  logic             memRead_EX,
    input  logic             RegWrite_EX,
    input  logic             set_flags_EX,
    input  logic [4:0]       targetReg_EX,
    input  logic             RegWrite_MEM,
    input  logic [4:0]       targetReg_MEM,
    input  logic             RegWrite_WB,
    input  logic [4:0]       targetReg_WB,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             IF_ID_write_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic [1:0]       FWDA,
    output logic [1:0]       FWDB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0]       c_mem_reload = 3'(MEM_LAT - 1);
    localparam logic [2:0]       c_br_reload  = 3'(BR_PENALTY - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic             w_load_haz;
    logic             w_flag_haz;
    logic             w_pc_write_en;
    logic             w_if_id_write_en;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_load_haz = memRead_EX && RegWrite_EX && (targetReg_EX != XZR) &&
                        ((uses_rn_ID && (Rn_ID == targetReg_EX)) ||
                         (uses_rm_ID && (Rm_ID == targetReg_EX)));
    assign w_flag_haz = condBr_ID && set_flags_EX;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pc_write_en    = 1'b1;
        w_if_id_write_en = 1'b1;
        w_if_id_flush    = 1'b0;
        w_id_ex_bubble   = 1'b0;
        if (rst) begin
            w_state_nxt      = RUN;
            w_cnt_nxt        = 3'd0;
            w_pc_write_en    = 1'b0;
            w_if_id_write_en = 1'b0;
            w_if_id_flush    = 1'b1;
            w_id_ex_bubble   = 1'b1;
        end else if (branch_taken) begin
            // Taken branch wins from any state; the PC still loads the target.
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            if (BR_PENALTY > 1) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = c_br_reload;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 3'd0;
            end
        end else begin
            case (r_state)
                STALL: begin
                    w_pc_write_en    = 1'b0;
                    w_if_id_write_en = 1'b0;
                    w_id_ex_bubble   = 1'b1;
                    w_cnt_nxt        = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) w_state_nxt = RUN;
                end
                FLUSH: begin
                    // The ID instruction is wrong-path, so hazards on it are moot.
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_cnt_nxt      = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) w_state_nxt = RUN;
                end
                default: begin
                    if (w_load_haz || w_flag_haz) begin
                        w_pc_write_en    = 1'b0;
                        w_if_id_write_en = 1'b0;
                        w_id_ex_bubble   = 1'b1;
                    end
                    if (w_load_haz && (MEM_LAT > 1)) begin
                        w_state_nxt = STALL;
                        w_cnt_nxt   = c_mem_reload;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write_en && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_if_id_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    fwd_select u_fwd_a (
        .src          (rn_EX),
        .regwrite_mem (RegWrite_MEM),
        .target_mem   (targetReg_MEM),
        .regwrite_wb  (RegWrite_WB),
        .target_wb    (targetReg_WB),
        .fwd          (w_fwd_a)
    );

    fwd_select u_fwd_b (
        .src          (rm_EX),
        .regwrite_mem (RegWrite_MEM),
        .target_mem   (targetReg_MEM),
        .regwrite_wb  (RegWrite_WB),
        .target_wb    (targetReg_WB),
        .fwd          (w_fwd_b)
    );

    assign pc_write_en    = w_pc_write_en;
    assign IF_ID_write_en = w_if_id_write_en;
    assign IF_ID_flush    = w_if_id_flush;
    assign ID_EX_bubble   = w_id_ex_bubble;
    assign FWDA           = rst ? FWD_REG : w_fwd_a;
    assign FWDB           = rst ? FWD_REG : w_fwd_b;
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;

endmodule
`default_nettype wire
